motor_emu: RTL and testbench

- Behavioural model of the motor-driver/encoder end of the PMOD motor interface, synthesisable.
- Consumes the PWM/direction/standby pins that the motor controller drives.
- Measures duty per PWM period, integrates a first-order speed model, and emits encoder feedback pulses for the controller's edge counters.
- Used for closed-loop simulation and for hardware-in-the-loop bring-up without a physical motor.

---
 rtl/motor_emu.sv | 160 ++++++++++++++++
 tb/tb_motor_emu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_emu.sv
// motor_emu: synthesisable stand-in for the motor driver and encoder of a PMOD
// motor interface. It measures PWM duty over fixed 2^PWM_BITS-cycle windows,
// decodes the drive mode from the direction and standby pins, runs a
// first-order speed model once per window, and turns speed into encoder pulses
// through a phase accumulator.
// Optional build macro: MOTOR_EMU_QUAD_EN adds a quadrature channel B (fb_b)
// using a 2-bit Gray state. Without it fb_b is tied low.
module motor_emu #(
  parameter int PWM_BITS  = 14,
  parameter int LAG_SHIFT = 2,
  parameter int PHASE_W   = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  input  logic                in1,
  input  logic                in2,
  input  logic                stnby,
  output logic                fb_out,
  output logic                fb_b,
  output logic [PWM_BITS-1:0] speed_out,
  output logic                dir_out,
  output logic [1:0]          mode_out,
  output logic                upd
);

  typedef enum logic [1:0] {
    MODE_COAST = 2'd0,
    MODE_FWD   = 2'd1,
    MODE_REV   = 2'd2,
    MODE_BRAKE = 2'd3
  } mode_e;

  // Two guard bits give room for the sign and for speed+step before clamping.
  localparam int SW = PWM_BITS + 2;
  localparam logic signed [SW-1:0] SPD_MAX = SW'((1 << PWM_BITS) - 1);

  logic [PWM_BITS-1:0]   win_cnt;
  logic [PWM_BITS:0]     high_cnt;
  logic [PHASE_W-1:0]    phase_acc;
  logic [PHASE_W:0]      phase_sum;
  logic                  tick;
  logic                  cyc_high;
  logic                  fb_event;
  logic [PWM_BITS-1:0]   duty;
  mode_e                 mode_now;
  logic                  dir_next;
  logic [PWM_BITS-1:0]   target;
  int                    shift_amt;
  logic signed [SW-1:0]  diff;
  logic signed [SW-1:0]  step;
  logic signed [SW-1:0]  sum;
  logic [PWM_BITS-1:0]   spd_next;

  assign tick     = &win_cnt;
  assign cyc_high = pwm_in & stnby;
  // A window that is high on every cycle counts 2^PWM_BITS; saturate to fit.
  assign duty     = high_cnt[PWM_BITS] ? '1 : high_cnt[PWM_BITS-1:0];

  // One carry out of the phase accumulator is one encoder event.
  assign phase_sum = {1'b0, phase_acc} + (PHASE_W+1)'(speed_out);
  assign fb_event  = phase_sum[PHASE_W];

  // Decode the drive mode from the pins on every cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    mode_now = MODE_COAST;
    if (stnby) begin
      unique case ({in1, in2})
        2'b10:   mode_now = MODE_FWD;
        2'b01:   mode_now = MODE_REV;
        2'b11:   mode_now = MODE_BRAKE;
        default: mode_now = MODE_COAST;
      endcase
    end
  end

  // Next speed and direction from the mode and duty seen on the tick cycle.
  always_comb begin
    dir_next  = dir_out;
    target    = '0;
    shift_amt = LAG_SHIFT;
    unique case (mode_now)
      MODE_FWD, MODE_REV: begin
        // An opposing request first decays to zero (plugging); the direction
        // only changes on a tick where the model is already stopped.
        if (((mode_now == MODE_REV) == dir_out) || (speed_out == '0)) begin
          dir_next = (mode_now == MODE_REV);
          target   = duty;
        end
      end
      MODE_BRAKE: shift_amt = 1;
      default:    shift_amt = LAG_SHIFT + 2;
    endcase

    diff = $signed({2'b00, target}) - $signed({2'b00, speed_out});
    step = diff >>> shift_amt;
    // A zero step with a nonzero error would stall short of the target.
    if ((diff != '0) && (step == '0)) step = diff[SW-1] ? '1 : SW'(1);
    sum = $signed({2'b00, speed_out}) + step;

    if (sum < 0)             spd_next = '0;
    else if (sum > SPD_MAX)  spd_next = '1;
    else                     spd_next = sum[PWM_BITS-1:0];
  end

  // Window counter, duty measurement, speed model and phase accumulator.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; a mid-window reset simply discards the window.
    if (rst) begin
      win_cnt   <= '0;
      high_cnt  <= '0;
      phase_acc <= '0;
      speed_out <= '0;
      dir_out   <= 1'b0;
      mode_out  <= MODE_COAST;
      upd       <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      win_cnt   <= win_cnt + 1'b1;
      phase_acc <= phase_sum[PHASE_W-1:0];
      upd       <= tick;
      if (tick) begin
        // The tick cycle's own high level opens the next window.
        high_cnt  <= (PWM_BITS+1)'(cyc_high);
        mode_out  <= mode_now;
        speed_out <= spd_next;
        dir_out   <= dir_next;
      end else begin
        high_cnt  <= high_cnt + (PWM_BITS+1)'(cyc_high);
      end
    end
  end

`ifdef MOTOR_EMU_QUAD_EN
  logic [1:0] q;

  assign fb_out = q[1];
  assign fb_b   = q[0];

  // Gray-step the quadrature state on each event, direction selects the order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 2'b00;
    end else if (fb_event) begin
      if (!dir_out) q <= {q[0], ~q[1]};
      else          q <= {~q[0], q[1]};
    end
  end
`else
  assign fb_b = 1'b0;

  // Toggle channel A on each event.
  always_ff @(posedge clk) begin
    if (rst)           fb_out <= 1'b0;
    else if (fb_event) fb_out <= ~fb_out;
  end
`endif

endmodule

// File: tb/tb_motor_emu.sv
// tb_motor_emu: directed checks of motor_emu. Instance A uses the full 14-bit
// window to confirm the first speed updates; instance B uses an 8-bit window so
// convergence, reversal, brake/coast, standby and mid-window reset fit a short run.
`timescale 1ns/1ps
module tb_motor_emu;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  // Instance A: PWM_BITS=14, PHASE_W=20
  logic        a_rst, a_pwm, a_in1, a_in2, a_stnby;
  logic        a_fb, a_fbb, a_dir, a_upd;
  logic [13:0] a_speed;
  logic [1:0]  a_mode;

  // Instance B: PWM_BITS=8, PHASE_W=12
  logic        b_rst, b_pwm, b_in1, b_in2, b_stnby;
  logic        b_fb, b_fbb, b_dir, b_upd;
  logic [7:0]  b_speed;
  logic [1:0]  b_mode;

  motor_emu #(.PWM_BITS(14), .LAG_SHIFT(2), .PHASE_W(20)) u_a (
    .clk(clk), .rst(a_rst), .pwm_in(a_pwm), .in1(a_in1), .in2(a_in2),
    .stnby(a_stnby), .fb_out(a_fb), .fb_b(a_fbb), .speed_out(a_speed),
    .dir_out(a_dir), .mode_out(a_mode), .upd(a_upd)
  );

  motor_emu #(.PWM_BITS(8), .LAG_SHIFT(2), .PHASE_W(12)) u_b (
    .clk(clk), .rst(b_rst), .pwm_in(b_pwm), .in1(b_in1), .in2(b_in2),
    .stnby(b_stnby), .fb_out(b_fb), .fb_b(b_fbb), .speed_out(b_speed),
    .dir_out(b_dir), .mode_out(b_mode), .upd(b_upd)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  logic sel_b    = 1'b0;
  logic duty25   = 1'b0;
  int   phase_b  = 0;
  logic cur_upd;

  assign cur_upd = sel_b ? b_upd : a_upd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; sample #1 after the edge, track B's window phase, drive B's PWM.
  task automatic step();
    @(posedge clk);
    #1;
    phase_b = (phase_b + 1) % 256;
    if (duty25) b_pwm = (phase_b < 64);
  endtask

  task automatic wait_upd(input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!cur_upd && cyc < limit);
    if (!cur_upd) check("upd_timeout", 32'd0, 32'd1);
  endtask

  task automatic skip_upd(input int n);
    int c;
    repeat (n) wait_upd(400, c);
  endtask

  initial begin
    int c, iv, changes;
    logic prev;

    a_rst = 1'b1; a_pwm = 1'b1; a_in1 = 1'b1; a_in2 = 1'b0; a_stnby = 1'b1;
    b_rst = 1'b1; b_pwm = 1'b1; b_in1 = 1'b1; b_in2 = 1'b0; b_stnby = 1'b1;

    // ---- Instance A: reset state and first full-on updates ----
    @(posedge clk);
    #1;
    check("a_rst_speed", 32'(a_speed), 32'd0);
    check("a_rst_dir",   32'(a_dir),   32'd0);
    check("a_rst_mode",  32'(a_mode),  32'd0);
    check("a_rst_upd",   32'(a_upd),   32'd0);
    check("a_rst_fb",    32'(a_fb),    32'd0);
    check("a_rst_fbb",   32'(a_fbb),   32'd0);
    a_rst = 1'b0;

    wait_upd(20000, c);
    check("a_upd_latency", 32'(c), 32'd16384);
    check("a_speed_1",  32'(a_speed), 32'd4095);
    check("a_mode_fwd", 32'(a_mode),  32'd1);
    check("a_dir_fwd",  32'(a_dir),   32'd0);
    step();
    check("a_upd_pulse", 32'(a_upd), 32'd0);
    wait_upd(20000, c);
    check("a_speed_2", 32'(a_speed), 32'd7167);
    wait_upd(20000, c);
    check("a_speed_3", 32'(a_speed), 32'd9471);

    // ---- Instance B: release reset, full-on forward convergence ----
    sel_b   = 1'b1;
    phase_b = 0;
    b_rst   = 1'b0;
    wait_upd(400, c);
    check("b_upd_latency", 32'(c), 32'd256);
    check("b_speed_1", 32'(b_speed), 32'd63);
    wait_upd(400, c);
    check("b_speed_2", 32'(b_speed), 32'd111);
    wait_upd(400, c);
    check("b_speed_3", 32'(b_speed), 32'd147);
    skip_upd(19);
    check("b_speed_conv", 32'(b_speed), 32'd255);
    check("b_mode_fwd",   32'(b_mode),  32'd1);

    // Toggle interval at full speed: 4096/255 cycles, so 16 or 17.
    prev = b_fb; c = 0;
    do begin step(); c++; end while (b_fb == prev && c < 200);
    prev = b_fb; iv = 0;
    do begin step(); iv++; end while (b_fb == prev && iv < 200);
    check("b_fb_period_16_17", 32'(iv >= 16 && iv <= 17), 32'd1);

    // ---- Reversal: decay to zero in old direction, then flip ----
    skip_upd(1);
    b_in1 = 1'b0; b_in2 = 1'b1;
    wait_upd(400, c);
    check("b_rev_speed_1", 32'(b_speed), 32'd191);
    check("b_rev_dir_1",   32'(b_dir),   32'd0);
    check("b_rev_mode",    32'(b_mode),  32'd2);
    skip_upd(15);
    wait_upd(400, c);
    check("b_rev_speed_0", 32'(b_speed), 32'd0);
    check("b_rev_dir_0",   32'(b_dir),   32'd0);
    wait_upd(400, c);
    check("b_rev_flip_dir",   32'(b_dir),   32'd1);
    check("b_rev_flip_speed", 32'(b_speed), 32'd63);

    // ---- Brake from 63: halves each tick down to zero ----
    b_in1 = 1'b1; b_in2 = 1'b1;
    wait_upd(400, c);
    check("b_brake_1",    32'(b_speed), 32'd31);
    check("b_brake_mode", 32'(b_mode),  32'd3);
    wait_upd(400, c);
    check("b_brake_2", 32'(b_speed), 32'd15);
    skip_upd(3);
    wait_upd(400, c);
    check("b_brake_0", 32'(b_speed), 32'd0);
    prev = b_fb; changes = 0;
    repeat (100) begin
      step();
      if (b_fb != prev) changes++;
      prev = b_fb;
    end
    check("b_fb_stopped", 32'(changes), 32'd0);

    // ---- Forward from standstill with dir=1, then coast ----
    b_in1 = 1'b1; b_in2 = 1'b0;
    wait_upd(400, c);
    check("b_fwd_dir",   32'(b_dir),   32'd0);
    check("b_fwd_speed", 32'(b_speed), 32'd63);
    b_in1 = 1'b0; b_in2 = 1'b0;
    wait_upd(400, c);
    check("b_coast_1",    32'(b_speed), 32'd59);
    check("b_coast_mode", 32'(b_mode),  32'd0);
    wait_upd(400, c);
    check("b_coast_2", 32'(b_speed), 32'd55);

    // ---- Standby overrides the direction pins ----
    b_stnby = 1'b0; b_in1 = 1'b1;
    wait_upd(400, c);
    check("b_stnby_speed", 32'(b_speed), 32'd51);
    check("b_stnby_mode",  32'(b_mode),  32'd0);

    // ---- Mid-window reset at win_cnt=100, then 25% duty ----
    b_stnby = 1'b1; b_in1 = 1'b1; b_in2 = 1'b0;
    duty25  = 1'b1;
    b_pwm   = (phase_b < 64);
    c = 0;
    while (phase_b != 100 && c < 300) begin step(); c++; end
    b_rst = 1'b1;
    step();
    phase_b = 0;
    b_pwm   = 1'b1;
    check("b_mrst_speed", 32'(b_speed), 32'd0);
    check("b_mrst_dir",   32'(b_dir),   32'd0);
    check("b_mrst_mode",  32'(b_mode),  32'd0);
    check("b_mrst_upd",   32'(b_upd),   32'd0);
    check("b_mrst_fb",    32'(b_fb),    32'd0);
    b_rst = 1'b0;
    wait_upd(400, c);
    check("b_mrst_latency", 32'(c), 32'd256);
    check("b_d25_1", 32'(b_speed), 32'd16);
    wait_upd(400, c);
    check("b_d25_2", 32'(b_speed), 32'd28);
    wait_upd(400, c);
    check("b_d25_3", 32'(b_speed), 32'd37);
    skip_upd(11);
    wait_upd(400, c);
    check("b_d25_conv", 32'(b_speed), 32'd64);
    skip_upd(3);
    check("b_d25_hold", 32'(b_speed), 32'd64);
    check("b_d25_dir",  32'(b_dir),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
